// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle controller: states, opcodes, mux selects, control word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package multicycle_control_pkg;

   typedef logic [3:0] state_t;

   localparam state_t S_FETCH    = 4'd0;
   localparam state_t S_DECODE   = 4'd1;
   localparam state_t S_MEMADR   = 4'd2;
   localparam state_t S_MEMREAD  = 4'd3;
   localparam state_t S_MEMWB    = 4'd4;
   localparam state_t S_MEMWRITE = 4'd5;
   localparam state_t S_EXECUTE  = 4'd6;
   localparam state_t S_ALUWB    = 4'd7;
   localparam state_t S_BRANCH   = 4'd8;
   localparam state_t S_ADDIEXEC = 4'd9;
   localparam state_t S_ADDIWB   = 4'd10;
   localparam state_t S_JUMP     = 4'd11;

   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   // ALU operand B select
   localparam logic [1:0] SRCB_REG   = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_BROFF = 2'b11;

   // ALU decoder class
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // Next-PC source
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // Per-state control word; pc_write and branch are folded into pc_en by the top.
   typedef struct packed {
      logic       pc_write;
      logic       branch;
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
   } ctrl_t;

   function automatic logic op_known(input logic [5:0] op);
      return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/multicycle_control_out_decode.sv
// State-to-control-word table for the multicycle controller (Moore outputs).
// Latency: combinational, zero cycles.
// Backpressure: none; pure decode of the current state.
module mc_out_decode
   import multicycle_control_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   // Every field defaults to 0; each state raises only its own strobes/selects.
   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.ir_write  = 1'b1;
            ctrl.pc_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
         end
         S_DECODE: begin
            ctrl.alu_src_b = SRCB_BROFF;
         end
         S_MEMADR, S_ADDIEXEC: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         S_MEMREAD: begin
            ctrl.iord = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         S_MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         S_ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         S_ADDIWB: begin
            ctrl.reg_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         S_BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.branch    = 1'b1;
         end
         S_JUMP: begin
            ctrl.pc_src   = PCSRC_JUMP;
            ctrl.pc_write = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS-style control FSM: state register, next-state logic, output decode.
// Latency: outputs follow state combinationally; one state step per clock.
// Backpressure: none; the FSM free-runs, opcode is assumed held by the IR after FETCH.
module multicycle_control
   import multicycle_control_pkg::*;
#(
   parameter int OPW = 6
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           zero,
   output logic           pc_en,
   output logic           iord,
   output logic           mem_write,
   output logic           ir_write,
   output logic           reg_dst,
   output logic           mem_to_reg,
   output logic           reg_write,
   output logic           alu_src_a,
   output logic [1:0]     alu_src_b,
   output logic [1:0]     alu_op,
   output logic [1:0]     pc_src,
   output logic           illegal_op,
   output logic [3:0]     state_dbg
);

   state_t     state;
   state_t     state_nxt;
   ctrl_t      ctrl;
   logic [5:0] op;

   assign op = 6'(opcode);

   // Next-state selection; any encoding outside the defined set falls back to FETCH.
   always_comb begin
      state_nxt = S_FETCH;
      case (state)
         S_FETCH: state_nxt = S_DECODE;
         S_DECODE: begin
            case (op)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_RTYPE:     state_nxt = S_EXECUTE;
               OP_BEQ:       state_nxt = S_BRANCH;
               OP_ADDI:      state_nxt = S_ADDIEXEC;
               OP_J:         state_nxt = S_JUMP;
               default:      state_nxt = S_FETCH;
            endcase
         end
         S_MEMADR:   state_nxt = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  state_nxt = S_MEMWB;
         S_EXECUTE:  state_nxt = S_ALUWB;
         S_ADDIEXEC: state_nxt = S_ADDIWB;
         default:    state_nxt = S_FETCH;
      endcase
   end

   // State register; reset returns to FETCH so an interrupted write is abandoned, not replayed.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_FETCH;
      end else begin
         state <= state_nxt;
      end
   end

   mc_out_decode u_out_decode (
      .state (state),
      .ctrl  (ctrl)
   );

   assign pc_en      = ctrl.pc_write | (ctrl.branch & zero);
   assign iord       = ctrl.iord;
   assign mem_write  = ctrl.mem_write;
   assign ir_write   = ctrl.ir_write;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign reg_write  = ctrl.reg_write;
   assign alu_src_a  = ctrl.alu_src_a;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign pc_src     = ctrl.pc_src;
   assign illegal_op = (state == S_DECODE) & ~op_known(op);
   assign state_dbg  = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control against an instruction-level reference model.
// Latency: checks every cycle, outputs sampled 1 time unit after the falling edge.
// Backpressure: n/a.
module tb_multicycle_control;
   import multicycle_control_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = 6'd0;
   logic       zero = 1'b0;
   logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
   logic [1:0] alu_src_b, alu_op, pc_src;
   logic       illegal_op;
   logic [3:0] state_dbg;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_cpi_q[$];
   int obs_cpi_q[$];
   int exp_writes = 0;
   int obs_writes = 0;
   int mon_cnt    = 0;

   multicycle_control #(.OPW(6)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .zero       (zero),
      .pc_en      (pc_en),
      .iord       (iord),
      .mem_write  (mem_write),
      .ir_write   (ir_write),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .reg_write  (reg_write),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .pc_src     (pc_src),
      .illegal_op (illegal_op),
      .state_dbg  (state_dbg)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic legal(input logic [5:0] op);
      return op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
   endfunction

   // Cycles per instruction as listed for the ISA.
   function automatic int cpi_of(input logic [5:0] op);
      case (op)
         6'b100011: return 5;
         6'b101011, 6'b000000, 6'b001000: return 4;
         6'b000100, 6'b000010: return 3;
         default: return 2;
      endcase
   endfunction

   // Expected outputs, each one stated as the set of states in which it is raised.
   function automatic logic [14:0] exp_outs(input state_t s, input logic z, input logic [5:0] op);
      logic       e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_sa, e_pc, e_ill;
      logic [1:0] e_sb, e_aop, e_psrc;
      e_iord = (s == S_MEMREAD) || (s == S_MEMWRITE);
      e_mw   = (s == S_MEMWRITE);
      e_irw  = (s == S_FETCH);
      e_rd   = (s == S_ALUWB);
      e_m2r  = (s == S_MEMWB);
      e_rw   = (s == S_MEMWB) || (s == S_ALUWB) || (s == S_ADDIWB);
      e_sa   = (s == S_MEMADR) || (s == S_ADDIEXEC) || (s == S_EXECUTE) || (s == S_BRANCH);
      e_sb   = (s == S_FETCH) ? 2'b01 : (s == S_DECODE) ? 2'b11 :
               ((s == S_MEMADR) || (s == S_ADDIEXEC)) ? 2'b10 : 2'b00;
      e_aop  = (s == S_EXECUTE) ? 2'b10 : (s == S_BRANCH) ? 2'b01 : 2'b00;
      e_psrc = (s == S_BRANCH) ? 2'b01 : (s == S_JUMP) ? 2'b10 : 2'b00;
      e_pc   = (s == S_FETCH) || (s == S_JUMP) || ((s == S_BRANCH) && z);
      e_ill  = (s == S_DECODE) && !legal(op);
      return {e_iord, e_mw, e_irw, e_rd, e_m2r, e_rw, e_sa, e_sb, e_aop, e_psrc, e_pc, e_ill};
   endfunction

   function automatic logic [14:0] got_outs();
      return {iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
              alu_src_b, alu_op, pc_src, pc_en, illegal_op};
   endfunction

   // Independent monitor: cycles between FETCH entries and total memory-write cycles.
   always @(negedge clk) begin
      #2;
      if (mem_write === 1'b1) obs_writes++;
      if (rst) begin
         mon_cnt = 0;
      end else if (state_dbg == S_FETCH) begin
         if (mon_cnt > 0) obs_cpi_q.push_back(mon_cnt);
         mon_cnt = 1;
      end else if (mon_cnt > 0) begin
         mon_cnt++;
      end
   end

   // Runs one instruction from its FETCH; zmode 0 random zero, 1 zero=0, 2 zero=1.
   // rst_at >= 0 raises reset in that step of the instruction.
   task automatic run_instr(input logic [5:0] op, input int zmode, input int rst_at);
      state_t seq[$];
      int     pc_cnt = 0;
      logic   zb = 1'b0;
      seq.push_back(S_FETCH);
      seq.push_back(S_DECODE);
      case (op)
         6'b100011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMREAD); seq.push_back(S_MEMWB); end
         6'b101011: begin seq.push_back(S_MEMADR); seq.push_back(S_MEMWRITE); end
         6'b000000: begin seq.push_back(S_EXECUTE); seq.push_back(S_ALUWB); end
         6'b000100: seq.push_back(S_BRANCH);
         6'b001000: begin seq.push_back(S_ADDIEXEC); seq.push_back(S_ADDIWB); end
         6'b000010: seq.push_back(S_JUMP);
         default: ;
      endcase
      for (int n = 0; n < seq.size(); n++) begin
         @(negedge clk);
         rst    = (n == rst_at);
         opcode = (n == 0) ? 6'($urandom) : op;
         zero   = (zmode == 0) ? 1'($urandom) : (zmode == 2);
         #1;
         chk("state", state_dbg, seq[n]);
         chk("outs", got_outs(), exp_outs(seq[n], zero, opcode));
         pc_cnt += int'(pc_en);
         if (seq[n] == S_BRANCH) zb = zero;
         if (seq[n] == S_MEMWRITE) exp_writes++;
         if (n == rst_at) break;
      end
      if (rst_at >= 0) begin
         @(negedge clk);
         zero = 1'($urandom);
         #1;
         chk("rst_mid_state", state_dbg, S_FETCH);
         chk("rst_mid_memwrite", mem_write, 1'b0);
      end else begin
         chk("pc_en_count", pc_cnt, 1 + int'(op == 6'b000010) + int'((op == 6'b000100) && zb));
         exp_cpi_q.push_back(cpi_of(op));
      end
   endtask

   logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};

   initial begin
      // Reset held for three clocks: FETCH outputs from the first edge onward.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         zero = 1'($urandom);
         #1;
         chk("rst_state", state_dbg, S_FETCH);
         chk("rst_outs", got_outs(), exp_outs(S_FETCH, zero, opcode));
      end
      run_instr(6'b100011, 0, -1);
      run_instr(6'b000100, 2, -1);
      run_instr(6'b000100, 1, -1);
      run_instr(6'b000000, 2, -1);
      run_instr(6'b111111, 0, -1);
      run_instr(6'b101011, 0, 3);
      run_instr(6'b000000, 0, -1);
      run_instr(6'b101011, 0, -1);
      run_instr(6'b000010, 0, -1);
      run_instr(6'b000000, 0, -1);
      run_instr(6'b001000, 0, -1);
      for (int k = 0; k < 60; k++) begin
         logic [5:0] op;
         op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
         run_instr(op, $urandom_range(0, 2), -1);
      end
      @(negedge clk);
      zero = 1'b0;
      #1;
      chk("final_state", state_dbg, S_FETCH);
      #5;
      chk("cpi_count", obs_cpi_q.size(), exp_cpi_q.size());
      for (int i = 0; i < exp_cpi_q.size() && i < obs_cpi_q.size(); i++)
         chk("cpi", obs_cpi_q[i], exp_cpi_q[i]);
      chk("mem_writes", obs_writes, exp_writes);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
